// File: rtl/keypad_pkg.sv
// Shared types and key-map decode for the 4x3 safe keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Rows 0-2 are the digits 1-9; row 3 is *, 0, #.
  function automatic logic [3:0] kp_decode(input logic [3:0] row, input logic [2:0] col);
    logic [3:0] base;
    logic [3:0] code;
    base = 4'd0;
    code = 4'd0;
    case (row)
      4'b0001: base = 4'd1;
      4'b0010: base = 4'd4;
      4'b0100: base = 4'd7;
      default: base = 4'd0;
    endcase
    if (row == 4'b1000) begin
      case (col)
        3'b001:  code = KEY_STAR;
        3'b010:  code = 4'd0;
        3'b100:  code = KEY_HASH;
        default: code = 4'd0;
      endcase
    end else begin
      case (col)
        3'b001:  code = base;
        3'b010:  code = base + 4'd1;
        3'b100:  code = base + 4'd2;
        default: code = 4'd0;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs,
// cleared together with the rest of the scanner.
module col_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         init,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (init) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Lock-on-press row scanner: dwells on each row, debounces a single-column
// press into one key_valid pulse, then waits for a debounced release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000000,
  parameter int DEBOUNCE_CNT = 200000
) (
  input  logic       clk,
  input  logic       init,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CNT - 1);
  localparam logic [DBW-1:0] DB_MAX     = DBW'(DEBOUNCE_CNT);

  kp_state_t      state;
  logic [DW-1:0]  dwell;
  logic [DBW-1:0] db;
  logic [DBW-1:0] db_inc;
  logic [2:0]     col_s;
  logic [2:0]     cap;
  logic [3:0]     row_rot;
  logic           col_one_hot;

  col_sync #(.W(3)) u_col_sync (
    .clk  (clk),
    .init (init),
    .din  (col),
    .dout (col_s)
  );

  always_comb begin
    row_rot     = {row[2:0], row[3]};
    col_one_hot = (col_s != 3'b000) && ((col_s & (col_s - 3'd1)) == 3'b000);
    db_inc      = (db == DB_MAX) ? db : db + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state     <= SCAN;
      dwell     <= '0;
      db        <= '0;
      cap       <= 3'b000;
      row       <= 4'b0001;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell != DWELL_LAST) begin
            dwell <= dwell + 1'b1;
          end else if (col_one_hot) begin
            // Row stays locked so the captured column decodes against it.
            cap   <= col_s;
            db    <= '0;
            dwell <= '0;
            state <= PRESS_DB;
          end else begin
            row   <= row_rot;
            dwell <= '0;
          end
        end
        PRESS_DB: begin
          if (col_s != cap) begin
            row   <= row_rot;
            dwell <= '0;
            state <= SCAN;
          end else if (db == DB_LAST) begin
            db        <= DB_MAX;
            key_valid <= 1'b1;
            key_code  <= kp_decode(row, cap);
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            db <= db_inc;
          end
        end
        HELD: begin
          if (col_s == 3'b000) begin
            db    <= '0;
            state <= REL_DB;
          end
        end
        REL_DB: begin
          if (col_s != 3'b000) begin
            state <= HELD;
          end else if (db == DB_LAST) begin
            db       <= DB_MAX;
            key_held <= 1'b0;
            row      <= row_rot;
            dwell    <= '0;
            state    <= SCAN;
          end else begin
            db <= db_inc;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_CNT=4 and a keypad contact model.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic [2:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [3:0] key_row = 4'b0000;
  logic [2:0] key_col = 3'b000;
  logic       contact = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // A pressed key only connects its column while its own row is driven.
  assign col = (contact && ((row & key_row) != 4'd0)) ? key_col : 3'b000;

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(4)) dut (
    .clk       (clk),
    .init      (init),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    init = 1'b1;
    step();
    step();
    init = 1'b0;
    tests_run++;
    if ({row, key_valid, key_code, key_held} !== {4'b0001, 1'b0, 4'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s_reset: row=%b valid=%b code=%0d held=%b, want row=0001 valid=0 code=0 held=0",
               tag, row, key_valid, key_code, key_held);
    end
  endtask

  task automatic test_reset();
    contact = 1'b0;
    do_reset("reset");
  endtask

  task automatic test_idle();
    logic [3:0] exp_row;
    contact = 1'b0;
    do_reset("idle");
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      exp_row = 4'b0001 << ((k / 8) % 4);
      tests_run++;
      if (row !== exp_row) begin
        tests_failed++;
        $display("FAIL idle_row k=%0d: got %b want %b", k, row, exp_row);
      end
      tests_run++;
      if (key_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_valid k=%0d: got %b want 0", k, key_valid);
      end
    end
  endtask

  task automatic test_press_5();
    key_row = 4'b0010;
    key_col = 3'b010;
    contact = 1'b1;
    do_reset("press5");
    for (int k = 1; k <= 115; k++) begin
      step();
      tests_run++;
      if (key_valid !== (k == 20)) begin
        tests_failed++;
        $display("FAIL press5_valid k=%0d: got %b want %b", k, key_valid, (k == 20));
      end
      tests_run++;
      if (key_held !== (k >= 20 && k < 115)) begin
        tests_failed++;
        $display("FAIL press5_held k=%0d: got %b want %b", k, key_held, (k >= 20 && k < 115));
      end
      if (k == 20) begin
        tests_run++;
        if (key_code !== 4'd5) begin
          tests_failed++;
          $display("FAIL press5_code: got %0d want 5", key_code);
        end
      end
      if (k >= 109) begin
        tests_run++;
        if (row !== ((k < 115) ? 4'b0010 : 4'b0100)) begin
          tests_failed++;
          $display("FAIL press5_row k=%0d: got %b want %b", k, row, ((k < 115) ? 4'b0010 : 4'b0100));
        end
      end
      if (k == 108) contact = 1'b0;
    end
    tests_run++;
    if (key_code !== 4'd5) begin
      tests_failed++;
      $display("FAIL press5_code_hold: got %0d want 5", key_code);
    end
  endtask

  task automatic test_bounce();
    int pulses;
    logic [3:0] code_seen;
    pulses = 0;
    code_seen = 4'd0;
    key_row = 4'b1000;
    key_col = 3'b001;
    contact = 1'b0;
    do_reset("bounce");
    for (int i = 0; i < 100 && row !== 4'b1000; i++) step();
    tests_run++;
    if (row !== 4'b1000) begin
      tests_failed++;
      $display("FAIL bounce_row_wait: got %b want 1000", row);
    end
    for (int s = 0; s < 20; s++) begin
      contact = ((s / 2) % 2) == 0;
      step();
      tests_run++;
      if (key_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL bounce_toggle_valid s=%0d: got %b want 0", s, key_valid);
      end
    end
    contact = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (key_valid === 1'b1) begin
        pulses++;
        code_seen = key_code;
      end
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL bounce_pulses: got %0d want 1", pulses);
    end
    tests_run++;
    if (code_seen !== 4'd10) begin
      tests_failed++;
      $display("FAIL bounce_code: got %0d want 10", code_seen);
    end
    tests_run++;
    if (key_held !== 1'b1) begin
      tests_failed++;
      $display("FAIL bounce_held: got %b want 1", key_held);
    end
  endtask

  task automatic test_chord();
    logic [3:0] exp_row;
    key_row = 4'b0001;
    key_col = 3'b011;
    contact = 1'b1;
    do_reset("chord");
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      exp_row = 4'b0001 << ((k / 8) % 4);
      tests_run++;
      if (row !== exp_row) begin
        tests_failed++;
        $display("FAIL chord_row k=%0d: got %b want %b", k, row, exp_row);
      end
      tests_run++;
      if (key_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL chord_valid k=%0d: got %b want 0", k, key_valid);
      end
    end
  endtask

  task automatic test_release_glitch();
    key_row = 4'b0001;
    key_col = 3'b100;
    contact = 1'b1;
    do_reset("glitch");
    for (int k = 1; k <= 31; k++) begin
      step();
      tests_run++;
      if (key_valid !== (k == 12)) begin
        tests_failed++;
        $display("FAIL glitch_valid k=%0d: got %b want %b", k, key_valid, (k == 12));
      end
      tests_run++;
      if (key_held !== (k >= 12 && k < 31)) begin
        tests_failed++;
        $display("FAIL glitch_held k=%0d: got %b want %b", k, key_held, (k >= 12 && k < 31));
      end
      tests_run++;
      if (row !== ((k < 31) ? 4'b0001 : 4'b0010)) begin
        tests_failed++;
        $display("FAIL glitch_row k=%0d: got %b want %b", k, row, ((k < 31) ? 4'b0001 : 4'b0010));
      end
      if (k == 12) begin
        tests_run++;
        if (key_code !== 4'd3) begin
          tests_failed++;
          $display("FAIL glitch_code: got %0d want 3", key_code);
        end
      end
      if (k == 20) contact = 1'b0;
      if (k == 23) contact = 1'b1;
      if (k == 24) contact = 1'b0;
    end
  endtask

  task automatic test_init_mid_debounce();
    key_row = 4'b0001;
    key_col = 3'b001;
    contact = 1'b1;
    do_reset("middb");
    for (int k = 1; k <= 10; k++) begin
      step();
      tests_run++;
      if (key_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL middb_pre_valid k=%0d: got %b want 0", k, key_valid);
      end
    end
    init = 1'b1;
    step();
    init = 1'b0;
    tests_run++;
    if ({row, key_valid, key_code, key_held} !== {4'b0001, 1'b0, 4'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL middb_reset: row=%b valid=%b code=%0d held=%b, want row=0001 valid=0 code=0 held=0",
               row, key_valid, key_code, key_held);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      tests_run++;
      if (key_valid !== (k == 12)) begin
        tests_failed++;
        $display("FAIL middb_post_valid k=%0d: got %b want %b", k, key_valid, (k == 12));
      end
    end
    tests_run++;
    if (key_code !== 4'd1) begin
      tests_failed++;
      $display("FAIL middb_fresh_code: got %0d want 1", key_code);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press_5();
    test_bounce();
    test_chord();
    test_release_glitch();
    test_init_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning front end for the 4x3 safe keypad. It drives the one-hot `row` lines and samples the three `col` lines through a synchronizer. Each press is debounced and reported to the safe controller as one `key_valid` pulse carrying a 4-bit key code. It then waits for a debounced release before it scans again. It sits between the board keypad pins and the safe FSM, replacing free-running row rotation with a lock-on-press scan.

## Interface
- `SCAN_DIV`, 1000000: clock cycles each row is driven (dwell), ≥4.
- `DEBOUNCE_CNT`, 200000: consecutive stable cycles required for press and for release, ≥1.
- `clk`  in  1  system clock; all logic on posedge.
- `init`  in  1  reset, synchronous, active-high; same signal as the board "initialize all" button.
- `col`  in  3  keypad columns, active-high, asynchronous to `clk`; bit0 = left column.
- `row`  out  4  one-hot row drive, registered; bit0 = top row.
- `key_valid`  out  1  one-cycle pulse: debounced press detected.
- `key_code`  out  4  key code; valid when `key_valid`=1, holds last value otherwise.
- `key_held`  out  1  high from the press pulse until release debounce completes.

## Operation
- Key map, as row/col to code. Row0: 1, 2, 3. Row1: 4, 5, 6. Row2: 7, 8, 9. Row3: `*`=10, 0, `#`=11. Codes 12–15 are never emitted.
- `col` passes through a 2-flop synchronizer. All decisions use the synchronized value `col_s`.
- The FSM has four states: SCAN, PRESS_DB, HELD, REL_DB.
- SCAN: `dwell` counts 0..SCAN_DIV-1 while `row` stays constant. At `dwell`=SCAN_DIV-1, `col_s` is evaluated:
  - `col_s`=000: rotate `row` 0001→0010→0100→1000→0001 and clear `dwell`.
  - Exactly one bit set: capture `col_s`, go PRESS_DB, clear `db`. `row` is not rotated.
  - Two or more bits set (chord): treated as no key; rotate.
- PRESS_DB: `db` increments each cycle that `col_s` equals the captured pattern. Any mismatch returns to SCAN, rotates `row` and clears `dwell`. When `db` reaches DEBOUNCE_CNT:
  - assert `key_valid` for one cycle;
  - load `key_code` from the current row and captured column;
  - set `key_held`;
  - go HELD.
- HELD: `row` stays locked. When `col_s`=000, go REL_DB and clear `db`.
- REL_DB: `db` increments while `col_s`=000. Any nonzero `col_s` returns to HELD with no new pulse.
  - When `db` reaches DEBOUNCE_CNT: clear `key_held`, rotate `row`, clear `dwell`, go SCAN.
- Holding a key therefore gives exactly one pulse. A second key pressed during HELD is ignored.
- Counters are `$clog2` wide and saturate at their terminal value; they never wrap.
- `init` has priority over every other event, in any state and mid-count.

## Timing
- Reset values (the cycle after `init` is sampled high):
  - `row`=0001, `key_valid`=0, `key_code`=0000, `key_held`=0;
  - state SCAN, `dwell`=0, `db`=0, synchronizer flops 0.
- A `col` edge appears in `col_s` 2 cycles later.
- Press latency: the SCAN sample cycle, then DEBOUNCE_CNT matching cycles. `key_valid` is high on the cycle after the last matching cycle.
- `key_valid` and `key_held` rise on the same edge.
- Release latency: DEBOUNCE_CNT zero cycles after HELD→REL_DB. `key_held` falls and `row` rotates on the same edge.
- `row` changes only on a rotate. After reset, the first rotate occurs at cycle SCAN_DIV with no key pressed.
- A mismatch in PRESS_DB on the final counting cycle still aborts, and no pulse is produced.

## Structure
- Package `keypad_pkg` holds:
  - state enum `kp_state_t` {SCAN, PRESS_DB, HELD, REL_DB};
  - constants `KEY_STAR`=4'd10, `KEY_HASH`=4'd11;
  - function `kp_decode(row, col)` returning the 4-bit code.
- Sub-module `col_sync`: a parameterized-width 2-flop synchronizer with synchronous `init` clear. It is instantiated once, 3 bits wide.

## Test plan
All scenarios run with SCAN_DIV=8 and DEBOUNCE_CNT=4.
- Reset and idle: `init` for 2 cycles, then `col`=000. Required: `row` is 0001 for 8 cycles, then 0010, 0100, 1000, 0001; `key_valid` never asserts.
- Clean press of "5": drive `col`=010 only while `row`=0010, held 100 cycles, then release. Required:
  - exactly one `key_valid` pulse with `key_code`=5;
  - `key_held` stays high until 4 zero cycles after the release propagates;
  - `row` then steps to 0100.
- Bounce: on `row`=1000, toggle `col`=001 every 2 cycles for 20 cycles, then hold it stable. Required:
  - no pulse during toggling;
  - a single pulse with `key_code`=10 after stabilization.
- Chord: `col`=011 on `row`=0001. Required: no pulse, and rotation continues on schedule.
- Release glitch: in REL_DB, drive `col`=100 for 1 cycle after 2 zero cycles. Required: back to HELD, `key_held` stays 1, no second pulse.
- Reset mid-debounce: assert `init` during PRESS_DB with `db`=2. Required: all outputs at reset values on the next cycle, and no pulse afterwards until a fresh press.
